// File: rtl/elevator_pkg.sv
// Shared constants, state encoding and floor-mask helpers for the elevator scheduler.
package elevator_pkg;

  localparam int NUM_FLOORS = 3;

  localparam logic [1:0] FLOOR_0 = 2'd0;
  localparam logic [1:0] FLOOR_1 = 2'd1;
  localparam logic [1:0] FLOOR_2 = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MOVING    = 2'd1,
    ST_DOOR_OPEN = 2'd2
  } state_e;

  // One-hot mask of a single floor, and masks of the floors strictly above/below it.
  function automatic logic [NUM_FLOORS-1:0] floorMask(input logic [1:0] f);
    logic [NUM_FLOORS-1:0] m;
    for (int i = 0; i < NUM_FLOORS; i++) m[i] = (i == int'(f));
    return m;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] aboveMask(input logic [1:0] f);
    logic [NUM_FLOORS-1:0] m;
    for (int i = 0; i < NUM_FLOORS; i++) m[i] = (i > int'(f));
    return m;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] belowMask(input logic [1:0] f);
    logic [NUM_FLOORS-1:0] m;
    for (int i = 0; i < NUM_FLOORS; i++) m[i] = (i < int'(f));
    return m;
  endfunction

endpackage

// File: rtl/button_sync.sv
// Two-flop synchroniser for an active-low call button plus a registered falling-edge pulse.
module button_sync (
  input  logic clk_i,
  input  logic reset_i,
  input  logic button_n_i,
  output logic fall_o
);

  logic sync1_q;
  logic sync2_q;
  logic hist_q;
  logic fall_q;

  // Flops reset to the released (high) level so a reset never looks like a press.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= button_n_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      fall_q  <= hist_q & ~sync2_q;
    end
  end

  assign fall_o = fall_q;

endmodule

// File: rtl/elevator_scheduler.sv
// Three-floor SCAN elevator controller; define ELEVATOR_DOOR_HOLD_EN to let a
// same-floor call restart the door timer while the door is open.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int FLOOR_TICKS = 10,
  parameter int DOOR_TICKS  = 5
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       tick,
  input  logic       button1,
  input  logic       button2,
  input  logic       button3,
  output logic [1:0] floor,
  output logic       moving,
  output logic       dir_up,
  output logic       door_open,
  output logic [2:0] pending
);

  localparam int MAX_TICKS = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS + 1);
  localparam logic [CNT_W-1:0] FLOOR_LAST = CNT_W'(FLOOR_TICKS - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST  = CNT_W'(DOOR_TICKS - 1);

  logic [NUM_FLOORS-1:0] press;

  button_sync u_sync0 (.clk_i(clk_50), .reset_i(reset), .button_n_i(button1), .fall_o(press[0]));
  button_sync u_sync1 (.clk_i(clk_50), .reset_i(reset), .button_n_i(button2), .fall_o(press[1]));
  button_sync u_sync2 (.clk_i(clk_50), .reset_i(reset), .button_n_i(button3), .fall_o(press[2]));

  state_e                state_q, state_d;
  logic [1:0]            floor_q, floor_d;
  logic                  dir_q, dir_d;
  logic [NUM_FLOORS-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  moving_q;
  logic                  door_q;

  logic [1:0]            nextFloor;
  logic [NUM_FLOORS-1:0] here, nextHere, ahead, behind;
  logic [NUM_FLOORS-1:0] setMask, clrMask;
  logic                  holdRestart;

  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    setMask   = press;
    clrMask   = '0;
    here      = floorMask(floor_q);
    nextFloor = dir_q ? (floor_q + 2'd1) : (floor_q - 2'd1);
    nextHere  = floorMask(nextFloor);
    ahead     = dir_q ? aboveMask(nextFloor) : belowMask(nextFloor);
    behind    = dir_q ? belowMask(nextFloor) : aboveMask(nextFloor);
`ifdef ELEVATOR_DOOR_HOLD_EN
    holdRestart = |(press & here);
`else
    holdRestart = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (|(pend_q & here)) begin
          state_d = ST_DOOR_OPEN;
        end else if (|(pend_q & aboveMask(floor_q))) begin
          state_d = ST_MOVING;
          dir_d   = 1'b1;
        end else if (|(pend_q & belowMask(floor_q))) begin
          state_d = ST_MOVING;
          dir_d   = 1'b0;
        end
      end
      // Direction only survives an arrival while requests lie ahead, which keeps floor in range.
      ST_MOVING: begin
        if (tick) begin
          if (cnt_q == FLOOR_LAST) begin
            cnt_d   = '0;
            floor_d = nextFloor;
            if (|(pend_q & nextHere)) begin
              clrMask = nextHere;
              state_d = ST_DOOR_OPEN;
            end else if (|(pend_q & ahead)) begin
              state_d = ST_MOVING;
            end else if (|(pend_q & behind)) begin
              dir_d   = ~dir_q;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DOOR_OPEN: begin
        setMask = press & ~here;
        if (holdRestart) begin
          cnt_d = '0;
        end else if (tick) begin
          if (cnt_q == DOOR_LAST) begin
            cnt_d   = '0;
            clrMask = here;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    pend_d = (pend_q | setMask) & ~clrMask;
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      floor_q  <= FLOOR_0;
      dir_q    <= 1'b1;
      pend_q   <= '0;
      cnt_q    <= '0;
      moving_q <= 1'b0;
      door_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      floor_q  <= floor_d;
      dir_q    <= dir_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      moving_q <= (state_d == ST_MOVING);
      door_q   <= (state_d == ST_DOOR_OPEN);
    end
  end

  assign floor     = floor_q;
  assign moving    = moving_q;
  assign dir_up    = dir_q;
  assign door_open = door_q;
  assign pending   = pend_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Randomised bench for elevator_scheduler against an event-level reference model.
module tb_elevator_scheduler;

  localparam int FLOOR_TICKS = 2;
  localparam int DOOR_TICKS  = 2;

  localparam int MODE_IDLE   = 0;
  localparam int MODE_TRAVEL = 1;
  localparam int MODE_DOOR   = 2;

  logic       clk_50;
  logic       reset;
  logic       tick;
  logic       button1, button2, button3;
  logic [1:0] floor;
  logic       moving;
  logic       dir_up;
  logic       door_open;
  logic [2:0] pending;

  int vectorCount;
  int miscompareCount;

  int       mFloor;
  bit       mDirUp;
  int       mMode;
  int       mLeft;
  bit [2:0] mPend;
  bit [2:0] mPrev;
  bit [2:0] evPipe [3];

  elevator_scheduler #(.FLOOR_TICKS(FLOOR_TICKS), .DOOR_TICKS(DOOR_TICKS)) dut (
    .clk_50   (clk_50),
    .reset    (reset),
    .tick     (tick),
    .button1  (button1),
    .button2  (button2),
    .button3  (button3),
    .floor    (floor),
    .moving   (moving),
    .dir_up   (dir_up),
    .door_open(door_open),
    .pending  (pending)
  );

  initial clk_50 = 1'b0;
  always #5 clk_50 = ~clk_50;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      miscompareCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic bit anyRequest(input bit [2:0] p, input int lo, input int hi);
    bit r;
    r = 1'b0;
    for (int i = lo; i <= hi; i++) if (i >= 0 && i <= 2 && p[i]) r = 1'b1;
    return r;
  endfunction

  // A call is a released-to-pressed transition of the sampled level; it lands in
  // the request set three clocks after the low level is first sampled.
  task automatic modelStep(input bit rst, input bit tk, input bit [2:0] btnLevel);
    bit [2:0] ev;
    bit [2:0] fallNow;
    bit [2:0] newPend;
    int       step;
    if (rst) begin
      mFloor = 0; mDirUp = 1'b1; mMode = MODE_IDLE; mLeft = 0;
      mPend = 3'b000; mPrev = 3'b111;
      for (int i = 0; i < 3; i++) evPipe[i] = 3'b000;
      return;
    end
    fallNow   = mPrev & ~btnLevel;
    mPrev     = btnLevel;
    ev        = evPipe[2];
    evPipe[2] = evPipe[1];
    evPipe[1] = evPipe[0];
    evPipe[0] = fallNow;
    newPend   = mPend | ev;
    case (mMode)
      MODE_IDLE: begin
        if (mPend[mFloor]) begin
          mMode = MODE_DOOR; mLeft = DOOR_TICKS;
        end else if (anyRequest(mPend, mFloor + 1, 2)) begin
          mMode = MODE_TRAVEL; mDirUp = 1'b1; mLeft = FLOOR_TICKS;
        end else if (anyRequest(mPend, 0, mFloor - 1)) begin
          mMode = MODE_TRAVEL; mDirUp = 1'b0; mLeft = FLOOR_TICKS;
        end
      end
      MODE_TRAVEL: begin
        if (tk) begin
          mLeft--;
          if (mLeft == 0) begin
            step   = mDirUp ? 1 : -1;
            mFloor = mFloor + step;
            mLeft  = FLOOR_TICKS;
            if (mPend[mFloor]) begin
              newPend[mFloor] = 1'b0;
              mMode = MODE_DOOR; mLeft = DOOR_TICKS;
            end else if (mDirUp ? anyRequest(mPend, mFloor + 1, 2) : anyRequest(mPend, 0, mFloor - 1)) begin
              mMode = MODE_TRAVEL;
            end else if (mDirUp ? anyRequest(mPend, 0, mFloor - 1) : anyRequest(mPend, mFloor + 1, 2)) begin
              mDirUp = !mDirUp;
            end else begin
              mMode = MODE_IDLE;
            end
          end
        end
      end
      default: begin
        newPend[mFloor] = mPend[mFloor];
`ifdef ELEVATOR_DOOR_HOLD_EN
        if (ev[mFloor]) mLeft = DOOR_TICKS;
        else if (tk) mLeft--;
`else
        if (tk) mLeft--;
`endif
        if (mLeft == 0) begin
          mMode = MODE_IDLE;
          newPend[mFloor] = 1'b0;
        end
      end
    endcase
    mPend = newPend;
  endtask

  task automatic applyStimulus(input bit rst, input bit tk, input bit [2:0] btnLevel);
    @(negedge clk_50);
    reset   = rst;
    tick    = tk;
    button1 = btnLevel[0];
    button2 = btnLevel[1];
    button3 = btnLevel[2];
    @(posedge clk_50);
    modelStep(rst, tk, btnLevel);
    #1;
    checkOutput("floor",     8'(floor),     8'(mFloor));
    checkOutput("moving",    8'(moving),    8'(mMode == MODE_TRAVEL));
    checkOutput("dirUp",     8'(dir_up),    8'(mDirUp));
    checkOutput("doorOpen",  8'(door_open), 8'(mMode == MODE_DOOR));
    checkOutput("pending",   8'(pending),   8'(mPend));
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 3'b111);
  endtask

  initial begin
    bit [2:0] level;
    bit       rst;
    bit       tk;
    vectorCount     = 0;
    miscompareCount = 0;
    reset = 1'b1; tick = 1'b1;
    button1 = 1'b1; button2 = 1'b1; button3 = 1'b1;
    modelStep(1'b1, 1'b1, 3'b111);

    $display("[TB] reset and floor-2 call from floor 0");
    applyStimulus(1'b1, 1'b1, 3'b111);
    applyStimulus(1'b1, 1'b1, 3'b111);
    applyStimulus(1'b0, 1'b1, 3'b011);
    idleCycles(16);

    $display("[TB] call at current floor");
    applyStimulus(1'b1, 1'b1, 3'b111);
    applyStimulus(1'b0, 1'b1, 3'b110);
    idleCycles(8);

    $display("[TB] intermediate stop on the way up");
    applyStimulus(1'b0, 1'b1, 3'b011);
    applyStimulus(1'b0, 1'b1, 3'b101);
    idleCycles(20);

    $display("[TB] SCAN reversal after serving the top floor");
    applyStimulus(1'b1, 1'b1, 3'b111);
    applyStimulus(1'b0, 1'b1, 3'b011);
    idleCycles(3);
    applyStimulus(1'b0, 1'b1, 3'b110);
    idleCycles(25);

    $display("[TB] reset mid-travel, then call with press during door phase");
    applyStimulus(1'b0, 1'b1, 3'b011);
    idleCycles(3);
    applyStimulus(1'b0, 1'b1, 3'b110);
    idleCycles(3);
    applyStimulus(1'b1, 1'b1, 3'b111);
    idleCycles(2);
    applyStimulus(1'b0, 1'b1, 3'b011);
    idleCycles(5);
    applyStimulus(1'b0, 1'b1, 3'b011);
    idleCycles(14);

    $display("[TB] random traffic");
    level = 3'b111;
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      tk  = ($urandom_range(0, 3) != 0);
      for (int b = 0; b < 3; b++) if ($urandom_range(0, 5) == 0) level[b] = ~level[b];
      applyStimulus(rst, tk, level);
    end
    idleCycles(30);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule

// File: doc/elevator_scheduler.md
ELEVATOR_SCHEDULER -- requirements
Module: elevator_scheduler

Interface
REQ-001 SHALL have parameter FLOOR_TICKS, default 10: tick count to travel one floor (>=1).
REQ-002 SHALL have parameter DOOR_TICKS, default 5: tick count the door stays open (>=1).
REQ-003 SHALL have port clk_50  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port tick  input  1  one-cycle timing enable from the frequency divider.
REQ-006 SHALL have ports button1, button2, button3  input  1 each  floor 0/1/2 call, active-low, asynchronous.
REQ-007 SHALL have port floor  output  2  last floor reached (0..2).
REQ-008 SHALL have port moving  output  1  cabin travelling; feeds the frequency divider.
REQ-009 SHALL have port dir_up  output  1  travel direction, 1 = up.
REQ-010 SHALL have port door_open  output  1  door open.
REQ-011 SHALL have port pending  output  3  latched requests, bit n = floor n.

Function
REQ-012 SHALL synchronise each button through 2 flops, then set pending[n] on the detected high-to-low edge; a press appears in pending exactly 3 cycles after the low level is first sampled.
REQ-013 SHALL capture button edges every cycle, independent of tick; timers and counters advance only on cycles with tick=1.
REQ-014 SHALL implement states IDLE, MOVING, DOOR_OPEN.
REQ-015 IDLE: pending[floor]=1 -> DOOR_OPEN next cycle; else any request above -> MOVING, dir_up=1; else any below -> MOVING, dir_up=0; else stay.
REQ-016 MOVING: travel counter counts ticks; at FLOOR_TICKS ticks, floor +/-1 per dir_up, counter clears.
REQ-017 On arrival, pending[new floor]=1 -> clear that bit, DOOR_OPEN; else continue in same direction.
REQ-018 Direction (SCAN): at a stop, keep dir_up while requests exist ahead; else reverse if requests behind; else IDLE.
REQ-019 DOOR_OPEN: door_open=1, moving=0; after DOOR_TICKS ticks -> IDLE with pending[floor] cleared.
REQ-020 moving SHALL equal 1 exactly while state is MOVING.
REQ-021 floor SHALL never leave 0..2; up-travel at floor 2 or down-travel at floor 0 SHALL not occur.
REQ-022 Set and clear of the same pending bit in one cycle: clear wins.
REQ-023 Request for current floor while MOVING stays pending; it is served later by SCAN.

Reset
REQ-024 On reset=1 at a clock edge: state IDLE, floor=0, moving=0, dir_up=1, door_open=0, pending=000, counters 0, sync flops 1 (released).
REQ-025 Reset mid-travel or mid-door SHALL discard all requests and position; no press during reset is latched.

Configuration
REQ-026 SHALL use macro ELEVATOR_DOOR_HOLD_EN: when defined, a new edge for the current floor during DOOR_OPEN restarts the door timer; when undefined, such an edge is dropped and the timer is unaffected.

Structure
REQ-027 SHALL take state encoding, NUM_FLOORS=3 and floor constants FLOOR_0..FLOOR_2 from shared package elevator_pkg.
REQ-028 SHALL instantiate sub-module button_sync (2-flop sync + falling-edge pulse) once per button.

Verification (FLOOR_TICKS=2, DOOR_TICKS=2, tick=1 every cycle)
REQ-029 Reset asserted 2 cycles -> floor=0, moving=0, dir_up=1, door_open=0, pending=000.
REQ-030 Idle at floor 0, pulse button3 -> pending=100, moving=1; floor 1 after 2 cycles, floor 2 after 4; door_open=1 for 2 cycles; pending=000, IDLE.
REQ-031 Idle at floor 0, pulse button1 -> door_open=1 without moving ever asserting; IDLE after 2 cycles.
REQ-032 From floor 0 moving to 2, pulse button2 before floor 1 arrival -> stop at floor 1 with door open, then continue to floor 2.
REQ-033 At floor 1 moving up with pending=101 -> serve floor 2 first, then dir_up=0, travel to floor 0; pending=000.
REQ-034 Reset mid-travel between floors 1 and 2 with pending=001 -> next cycle floor=0, IDLE, pending=000; repeat REQ-030 with and without ELEVATOR_DOOR_HOLD_EN, pressing button3 during the door phase.
